// File: rtl/fpa_pipe_if.sv
// rtl/fpa_pipe_if.sv - operand/result handshake bundle for the pipelined FP adder
interface fpa_pipe_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fpa_pipe.sv
// rtl/fpa_pipe.sv - multi-cycle IEEE-754-style add/sub with RNE rounding and status flags
module fpa_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    fpa_pipe_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;            // {hidden, fraction, guard, round, sticky}
    localparam int EW = EXP_W + 2;            // signed exponent work width
    localparam logic [EW-1:0]        SH_MAX = EW'(MAN_W + 3);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t r_state, w_state_nx;

    logic                  r_in_ready, r_out_valid;
    logic [W-1:0]          r_a, r_b, r_res, r_spec_res;
    logic [3:0]            r_flags, r_spec_flags;
    logic                  r_sx, r_sy, r_zero, r_special;
    logic signed [EW-1:0]  r_ex;
    logic [SW-1:0]         r_mx, r_my, r_man;
    logic [SW:0]           r_sum;

    logic                  w_accept, w_deliver;

    assign w_accept      = bus.in_valid && r_in_ready;
    assign w_deliver     = r_out_valid && bus.out_ready;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_res;
    assign bus.flags     = r_flags;

    // Next-state sequencing: fixed walk through the stages, wait in DONE for the consumer
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nx = ALIGN;
            ALIGN:   w_state_nx = ADD;
            ADD:     w_state_nx = NORM;
            NORM:    w_state_nx = ROUND;
            ROUND:   w_state_nx = DONE;
            DONE:    if (w_deliver) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Alignment: classify operands, order by magnitude, shift the smaller one with sticky
    logic                   w_sa, w_sb, w_za, w_zb, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_swap, w_special;
    logic [EXP_W-1:0]       w_ea, w_eb, w_ex, w_ey;
    logic [MAN_W-1:0]       w_fa, w_fb;
    logic [EXP_W+MAN_W-1:0] w_mag_a, w_mag_b;
    logic [SW-1:0]          w_siga, w_sigb, w_mx, w_my_raw, w_my_sh, w_mask;
    logic [EW-1:0]          w_d;
    logic [W-1:0]           w_spec_res;
    logic [3:0]             w_spec_flags;
    always_comb begin
        w_sa     = r_a[W-1];
        w_sb     = r_b[W-1];
        w_ea     = r_a[W-2:MAN_W];
        w_eb     = r_b[W-2:MAN_W];
        w_fa     = r_a[MAN_W-1:0];
        w_fb     = r_b[MAN_W-1:0];
        w_za     = (w_ea == '0);
        w_zb     = (w_eb == '0);
        w_nan_a  = (&w_ea) && (|w_fa);
        w_nan_b  = (&w_eb) && (|w_fb);
        w_inf_a  = (&w_ea) && !(|w_fa);
        w_inf_b  = (&w_eb) && !(|w_fb);
        // denormals are flushed: zero exponent means magnitude zero
        w_mag_a  = w_za ? '0 : {w_ea, w_fa};
        w_mag_b  = w_zb ? '0 : {w_eb, w_fb};
        w_siga   = w_za ? '0 : {1'b1, w_fa, 3'b000};
        w_sigb   = w_zb ? '0 : {1'b1, w_fb, 3'b000};
        w_swap   = (w_mag_b > w_mag_a);
        w_ex     = w_swap ? w_eb : w_ea;
        w_ey     = w_swap ? w_ea : w_eb;
        w_mx     = w_swap ? w_sigb : w_siga;
        w_my_raw = w_swap ? w_siga : w_sigb;
        w_d      = {2'b00, w_ex} - {2'b00, w_ey};
        w_mask   = ~({SW{1'b1}} << w_d);
        if (w_d >= SH_MAX)
            w_my_sh = {{(SW-1){1'b0}}, |w_my_raw};
        else
            w_my_sh = (w_my_raw >> w_d) | {{(SW-1){1'b0}}, |(w_my_raw & w_mask)};
        w_special    = w_nan_a || w_nan_b || w_inf_a || w_inf_b;
        w_spec_res   = QNAN;
        w_spec_flags = 4'b0000;
        if (w_nan_a || w_nan_b) begin
            w_spec_res = QNAN;
        end else if (w_inf_a && w_inf_b && (w_sa != w_sb)) begin
            w_spec_flags = 4'b1000;
        end else if (w_inf_a) begin
            w_spec_res = r_a;
        end else begin
            w_spec_res = r_b;
        end
    end

    // Add/subtract magnitudes and locate the leading one of the sum
    logic [SW:0]   w_sum;
    logic [EW-1:0] w_lzc;
    logic [SW-1:0] w_shl;
    always_comb begin
        w_sum = (r_sx == r_sy) ? ({1'b0, r_mx} + {1'b0, r_my}) : ({1'b0, r_mx} - {1'b0, r_my});
        w_lzc = '0;
        for (int i = 0; i < SW; i++) begin
            if (r_sum[i]) w_lzc = EW'(SW - 1 - i);
        end
        w_shl = r_sum[SW-1:0] << w_lzc;
    end

    // Round to nearest even and resolve overflow, underflow and specials into the output word
    logic                 w_g, w_r, w_s, w_up;
    logic [MAN_W+1:0]     w_rnd;
    logic [MAN_W-1:0]     w_rfrac;
    logic signed [EW-1:0] w_rexp;
    logic [W-1:0]         w_res;
    logic [3:0]           w_flags;
    always_comb begin
        w_g     = r_man[2];
        w_r     = r_man[1];
        w_s     = r_man[0];
        w_up    = w_g && (w_r || w_s || r_man[3]);
        w_rnd   = {1'b0, r_man[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
        w_rexp  = r_ex + EW'(w_rnd[MAN_W+1]);
        w_rfrac = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
        w_res   = {r_sx, w_rexp[EXP_W-1:0], w_rfrac};
        w_flags = {3'b000, w_g || w_r || w_s};
        if (r_special) begin
            w_res   = r_spec_res;
            w_flags = r_spec_flags;
        end else if (r_zero) begin
            w_res   = {r_sx, {(W-1){1'b0}}};
            w_flags = 4'b0000;
        end else if (w_rexp >= E_MAX) begin
            w_res   = {r_sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags = 4'b0101;
        end else if (w_rexp[EW-1] || (w_rexp == '0)) begin
            w_res   = {r_sx, {(W-1){1'b0}}};
            w_flags = 4'b0011;
        end
    end

    // Stage registers; valid is raised one cycle after DONE entry so the result word is settled first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_res        <= '0;
            r_flags      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sx         <= 1'b0;
            r_sy         <= 1'b0;
            r_ex         <= '0;
            r_mx         <= '0;
            r_my         <= '0;
            r_sum        <= '0;
            r_man        <= '0;
            r_zero       <= 1'b0;
            r_special    <= 1'b0;
            r_spec_res   <= '0;
            r_spec_flags <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_in_ready  <= (w_state_nx == IDLE);
            r_out_valid <= (r_state == DONE) && !w_deliver;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_a <= bus.a;
                    r_b <= {bus.b[W-1] ^ bus.sub, bus.b[W-2:0]};
                end
                ALIGN: begin
                    r_sx         <= w_swap ? w_sb : w_sa;
                    r_sy         <= w_swap ? w_sa : w_sb;
                    r_ex         <= {2'b00, w_ex};
                    r_mx         <= w_mx;
                    r_my         <= w_my_sh;
                    r_special    <= w_special;
                    r_spec_res   <= w_spec_res;
                    r_spec_flags <= w_spec_flags;
                end
                ADD: r_sum <= w_sum;
                NORM: begin
                    if (r_sum[SW]) begin
                        r_man  <= {r_sum[SW:2], r_sum[1] | r_sum[0]};
                        r_ex   <= r_ex + EW'(1);
                        r_zero <= 1'b0;
                    end else if (r_sum == '0) begin
                        r_man  <= '0;
                        r_sx   <= r_sx & r_sy;
                        r_zero <= 1'b1;
                    end else begin
                        r_man  <= w_shl;
                        r_ex   <= r_ex - w_lzc;
                        r_zero <= 1'b0;
                    end
                end
                ROUND: begin
                    r_res   <= w_res;
                    r_flags <= w_flags;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpa_pipe.sv
// tb/tb_fpa_pipe.sv - directed self-checking bench for fpa_pipe (single and half precision)
module tb_fpa_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpa_pipe_if #(.W(32)) bs ();
    fpa_pipe_if #(.W(16)) bh ();

    fpa_pipe #(.EXP_W(8), .MAN_W(23)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bs.slave));
    fpa_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (.clk(clk), .rst_n(rst_n), .bus(bh.slave));

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_s(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         output logic [31:0] res, output logic [3:0] fl, output int lat, output bit to);
        int n = 0;
        to = 1'b0; lat = 0; res = '0; fl = '0;
        while (!bs.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        bs.a = ia; bs.b = ib; bs.sub = isub; bs.in_valid = 1'b1;
        @(posedge clk); #1;
        bs.in_valid = 1'b0;
        while (!bs.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!bs.out_valid) begin
            to = 1'b1;
        end else begin
            res = bs.result; fl = bs.flags;
            bs.out_ready = 1'b1;
            @(posedge clk); #1;
            bs.out_ready = 1'b0;
        end
    endtask

    task automatic run_h(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                         output logic [15:0] res, output logic [3:0] fl, output bit to);
        int n = 0;
        int lat = 0;
        to = 1'b0; res = '0; fl = '0;
        while (!bh.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        bh.a = ia; bh.b = ib; bh.sub = isub; bh.in_valid = 1'b1;
        @(posedge clk); #1;
        bh.in_valid = 1'b0;
        while (!bh.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!bh.out_valid) begin
            to = 1'b1;
        end else begin
            res = bh.result; fl = bh.flags;
            bh.out_ready = 1'b1;
            @(posedge clk); #1;
            bh.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bs.in_ready !== 1'b1 || bs.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1 0", bs.in_ready, bs.out_valid);
        end
        n_checks++;
        if (bs.result !== 32'h0 || bs.flags !== 4'h0) begin
            n_fail++; $display("FAIL reset_data: result=%h flags=%b expected 0 0", bs.result, bs.flags);
        end
        n_checks++;
        if (bh.in_ready !== 1'b1 || bh.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_half: in_ready=%b out_valid=%b expected 1 0", bh.in_ready, bh.out_valid);
        end
    endtask

    task automatic test_basic_add();
        logic [31:0] r; logic [3:0] f; int lat; bit to;
        run_s(32'h3F800000, 32'h3F800000, 1'b0, r, f, lat, to);
        n_checks++;
        if (to || r !== 32'h40000000 || f !== 4'b0000) begin
            n_fail++; $display("FAIL basic_add: got %h/%b to=%0d expected 40000000/0000", r, f, to);
        end
        n_checks++;
        if (lat !== 5) begin
            n_fail++; $display("FAIL latency: got %0d cycles expected 5", lat);
        end
    endtask

    task automatic test_subtract();
        logic [31:0] va [4] = '{32'h3FC00000, 32'h40490FDB, 32'h3F800000, 32'h00800000};
        logic [31:0] vb [4] = '{32'h3F800000, 32'h40490FDB, 32'h40000000, 32'h00C00000};
        logic [31:0] ve [4] = '{32'h3F000000, 32'h00000000, 32'hBF800000, 32'h80000000};
        logic [3:0]  vf [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0011};
        logic [31:0] r; logic [3:0] f; int lat; bit to;
        for (int i = 0; i < 4; i++) begin
            run_s(va[i], vb[i], 1'b1, r, f, lat, to);
            n_checks++;
            if (to || r !== ve[i] || f !== vf[i]) begin
                n_fail++; $display("FAIL subtract[%0d]: got %h/%b to=%0d expected %h/%b", i, r, f, to, ve[i], vf[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] vb [3] = '{32'h33800000, 32'h33C00000, 32'h1F800000};
        logic [31:0] ve [3] = '{32'h3F800000, 32'h3F800001, 32'h3F800000};
        logic [31:0] r; logic [3:0] f; int lat; bit to;
        for (int i = 0; i < 3; i++) begin
            run_s(32'h3F800000, vb[i], 1'b0, r, f, lat, to);
            n_checks++;
            if (to || r !== ve[i] || f !== 4'b0001) begin
                n_fail++; $display("FAIL rounding[%0d]: got %h/%b to=%0d expected %h/0001", i, r, f, to, ve[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [3] = '{32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001};
        logic [31:0] vb [3] = '{32'h7F7FFFFF, 32'hFF800000, 32'h3F800000};
        logic [31:0] ve [3] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000};
        logic [3:0]  vf [3] = '{4'b0101, 4'b1000, 4'b0000};
        logic [31:0] r; logic [3:0] f; int lat; bit to;
        for (int i = 0; i < 3; i++) begin
            run_s(va[i], vb[i], 1'b0, r, f, lat, to);
            n_checks++;
            if (to || r !== ve[i] || f !== vf[i]) begin
                n_fail++; $display("FAIL specials[%0d]: got %h/%b to=%0d expected %h/%b", i, r, f, to, ve[i], vf[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bs.a = 32'h3F800000; bs.b = 32'h40000000; bs.sub = 1'b0; bs.in_valid = 1'b1;
        @(posedge clk); #1;
        bs.in_valid = 1'b0;
        while (!bs.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (bs.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_valid: out_valid=%b expected 1", bs.out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            bs.a = 32'h7F800000; bs.b = 32'h7F800000; bs.in_valid = (c != 1);
            @(posedge clk); #1;
            n_checks++;
            if (bs.out_valid !== 1'b1 || bs.in_ready !== 1'b0 || bs.result !== 32'h40400000 || bs.flags !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b result=%h flags=%b expected 1 0 40400000 0000",
                         c, bs.out_valid, bs.in_ready, bs.result, bs.flags);
            end
        end
        bs.in_valid = 1'b0;
        bs.out_ready = 1'b1;
        @(posedge clk); #1;
        bs.out_ready = 1'b0;
        n_checks++;
        if (bs.out_valid !== 1'b0 || bs.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: valid=%b ready=%b expected 0 1", bs.out_valid, bs.in_ready);
        end
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (bs.out_valid !== 1'b0 || bs.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_ignored: valid=%b ready=%b expected 0 1", bs.out_valid, bs.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [3:0] f; int lat; bit to;
        bs.a = 32'h3F800000; bs.b = 32'h3F800000; bs.sub = 1'b0; bs.in_valid = 1'b1;
        @(posedge clk); #1;
        bs.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bs.out_valid !== 1'b0 || bs.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid: valid=%b ready=%b expected 0 1", bs.out_valid, bs.in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (bs.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_discard: out_valid=%b expected 0", bs.out_valid);
        end
        run_s(32'h3FC00000, 32'h3FC00000, 1'b0, r, f, lat, to);
        n_checks++;
        if (to || r !== 32'h40400000 || f !== 4'b0000) begin
            n_fail++; $display("FAIL reset_next: got %h/%b to=%0d expected 40400000/0000", r, f, to);
        end
    endtask

    task automatic test_half();
        logic [15:0] r; logic [3:0] f; bit to;
        run_h(16'h3C00, 16'h3C00, 1'b0, r, f, to);
        n_checks++;
        if (to || r !== 16'h4000 || f !== 4'b0000) begin
            n_fail++; $display("FAIL half_add: got %h/%b to=%0d expected 4000/0000", r, f, to);
        end
        run_h(16'h7BFF, 16'h7BFF, 1'b0, r, f, to);
        n_checks++;
        if (to || r !== 16'h7C00 || f !== 4'b0101) begin
            n_fail++; $display("FAIL half_ovf: got %h/%b to=%0d expected 7C00/0101", r, f, to);
        end
    endtask

    initial begin
        bs.in_valid = 1'b0; bs.a = '0; bs.b = '0; bs.sub = 1'b0; bs.out_ready = 1'b0;
        bh.in_valid = 1'b0; bh.a = '0; bh.b = '0; bh.sub = 1'b0; bh.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic_add();
        test_subtract();
        test_rounding();
        test_specials();
        test_backpressure();
        test_reset_mid();
        test_half();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
